seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
- Upstream scan controller for the 8-digit multiplexed 7-segment display.
- Holds eight 4-bit digit registers that the host writes, and time-multiplexes them onto the display.
- Emits a 3-bit digit index that drives the 3-to-8 digit-select decoder, plus the current digit nibble for the segment encoder.
- Inserts a blanking interval at every digit change to suppress ghosting.

Parameters:
- PRESCALE, 1000: clock cycles per digit slot, blank plus show. Legal range 2..65535.
- BLANK_CYCLES, 4: cycles at the start of each slot with the display disabled. Must satisfy 1 <= BLANK_CYCLES < PRESCALE.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable for the digit register file.
- waddr  input  3  digit register index to write.
- wdata  input  4  nibble to write.
- blank_mask  input  8  bit i=1 keeps digit i dark for the whole of its slot.
- digit_sel  output  3  current digit index; feeds the 3-to-8 decoder input.
- digit_en  output  1  1 = current digit lit. Gates the decoder outputs downstream.
- digit_val  output  4  nibble displayed in the current slot.
- frame_tick  output  1  one-cycle pulse when a new frame starts, i.e. digit_sel wraps 7->0.

Behaviour:
- Synchronous, active-high reset, sampled on the clk edge. Reset values:
  - digit registers all 0; slot counter cnt = 0; state BLANK.
  - digit_sel = 0, digit_en = 0, digit_val = 0, frame_tick = 0.
- Reset asserted mid-operation overrides all activity, including a concurrent write. There is no partial-slot carryover.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Register file:
  - When we=1, reg[waddr] <= wdata at the edge.
  - Writes are accepted in any state, every cycle. A new write overrides the previous one.
- Slot counter:
  - cnt counts 0..PRESCALE-1. It wraps to 0 at the slot end and never saturates.
  - Width is the minimal width holding PRESCALE-1.
- State machine, two states:
  - BLANK:
    - digit_en = 0.
    - Leave BLANK on the edge where cnt == BLANK_CYCLES-1.
    - On that edge: state <= SHOW, digit_val <= reg[digit_sel], digit_en <= ~blank_mask[digit_sel].
  - SHOW:
    - digit_val is held constant for the whole SHOW phase. Writes to the displayed digit appear at that digit's next slot (glitch-free).
    - digit_en is latched at SHOW entry. blank_mask changes take effect at the next slot.
    - Leave SHOW on the edge where cnt == PRESCALE-1.
    - On that edge: state <= BLANK, digit_en <= 0, digit_sel <= digit_sel+1 (mod 8).
    - If digit_sel was 7, frame_tick <= 1 for exactly one cycle; otherwise frame_tick <= 0.
- digit_sel changes only on SHOW->BLANK edges, so the decoder input never changes while digit_en = 1.
- Timing:
  - Slot period is exactly PRESCALE cycles; frame period is 8*PRESCALE cycles.
  - After reset deasserts, the first digit_en rise (digit 0, if unmasked) is BLANK_CYCLES cycles later.
- Simultaneous write and latch: if we=1 with waddr == digit_sel on the BLANK->SHOW edge, digit_val takes wdata (write-through bypass).
- digit_val for a masked digit is still loaded normally; only digit_en is suppressed.

Test Plan (PRESCALE=8, BLANK_CYCLES=2):
1. Reset, then idle 64 cycles.
   -> digit_sel steps 0..7 every 8 cycles.
   -> digit_en high 6 of every 8 cycles, first rise 2 cycles after reset release.
   -> digit_val = 0 throughout; frame_tick pulses once per 64 cycles, on the 7->0 transition.
2. Write reg[i] = i+3 for i=0..7, then run one frame.
   -> digit_val = 3,4,...,10 in slot order, each stable for all 6 SHOW cycles.
3. During digit 5's SHOW, write reg[5] = 0xF.
   -> digit_val stays at its old value for the rest of that slot.
   -> digit 5 shows 0xF in the next frame.
4. On the BLANK->SHOW edge of digit 2, write reg[2] = 0xA.
   -> digit_val = 0xA in that same slot (bypass).
5. Set blank_mask = 8'b1000_0001.
   -> digit_en stays 0 during the slots of digits 0 and 7.
   -> digit_sel still advances and frame_tick still pulses.
6. Assert rst for 1 cycle in mid-SHOW of digit 4, with we=1 on the same cycle.
   -> Next cycle: all outputs 0, state BLANK, all registers 0, the write discarded.
   -> Scan restarts at digit 0.

Source files
------------

// File: rtl/seg_scan_if.sv
// Bus bundle between the host and the 8-digit 7-segment scan controller.
//   we, waddr, wdata : host writes one 4-bit digit register per cycle
//   blank_mask       : bit i=1 keeps digit i dark for its whole slot
//   digit_sel        : current digit index, drives the 3-to-8 decoder
//   digit_en         : 1 = current digit lit
//   digit_val        : nibble shown in the current slot
//   frame_tick       : one-cycle pulse when digit_sel wraps 7->0
// master = host side, slave = scan controller side.
interface seg_scan_if;
    logic       we;
    logic [2:0] waddr;
    logic [3:0] wdata;
    logic [7:0] blank_mask;
    logic [2:0] digit_sel;
    logic       digit_en;
    logic [3:0] digit_val;
    logic       frame_tick;

    modport master (
        output we, waddr, wdata, blank_mask,
        input  digit_sel, digit_en, digit_val, frame_tick
    );

    modport slave (
        input  we, waddr, wdata, blank_mask,
        output digit_sel, digit_en, digit_val, frame_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit multiplexed 7-segment display.
// Holds eight host-written 4-bit digit registers and time-multiplexes them
// onto the display, one PRESCALE-cycle slot per digit. Each slot starts with
// BLANK_CYCLES of darkness to suppress ghosting, then shows the digit.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : seg_scan_if.slave (write port, blank mask, display outputs)
// All outputs are registered.
module seg_scan_ctrl #(
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input logic     clk,
    input logic     rst,
    seg_scan_if.slave bus
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       regs [8];
    logic [2:0]       sel;
    logic             en;
    logic [3:0]       val;
    logic             tick;
    logic             enter_show;
    logic             leave_show;
    logic [3:0]       latch_val;

    always_comb begin
        state_next = state;
        enter_show = 1'b0;
        leave_show = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_next = SHOW;
                    enter_show = 1'b1;
                end
            end
            SHOW: begin
                if (cnt == CNT_LAST) begin
                    state_next = BLANK;
                    leave_show = 1'b1;
                end
            end
            default: state_next = BLANK;
        endcase
    end

    // A write landing on the latch edge for the digit being latched is
    // forwarded so the slot shows the freshly written nibble.
    always_comb begin
        latch_val = regs[sel];
        if (bus.we && (bus.waddr == sel)) begin
            latch_val = bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BLANK;
            cnt   <= '0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 4'd0;
            end
            sel   <= 3'd0;
            en    <= 1'b0;
            val   <= 4'd0;
            tick  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            if (bus.we) begin
                regs[bus.waddr] <= bus.wdata;
            end
            tick <= 1'b0;
            // digit_val and digit_en are frozen for the whole SHOW phase so
            // writes and mask changes never glitch a lit digit.
            if (enter_show) begin
                val <= latch_val;
                en  <= ~bus.blank_mask[sel];
            end
            // digit_sel only moves while the display is dark.
            if (leave_show) begin
                en   <= 1'b0;
                sel  <= sel + 3'd1;
                tick <= (sel == 3'd7);
            end
        end
    end

    assign bus.digit_sel  = sel;
    assign bus.digit_en   = en;
    assign bus.digit_val  = val;
    assign bus.frame_tick = tick;

endmodule
